lifo_stack_param: RTL



---
 rtl/lifo_stack_param.sv | 126 ++++++++++++
 1 files changed

// File: rtl/lifo_stack_param.sv
// Parametrised synchronous LIFO with occupancy count, top-of-stack peek, almost-full
// threshold, replace-top on simultaneous push+pop, and sticky overflow/underflow flags.
module lifo_stack_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    input  logic                       err_clr,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] top_word;
    logic             is_empty;
    logic             is_full;

    // The write pointer is the count itself; the top entry sits one below it.
    assign top_idx  = AW'(count_q - ONE_C);
    assign wr_idx   = AW'(count_q);
    assign top_word = mem_q[top_idx];
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_C);

    always_comb begin
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        overflow_d   = err_clr ? 1'b0 : overflow_q;
        underflow_d  = err_clr ? 1'b0 : underflow_q;
        mem_we       = 1'b0;
        mem_waddr    = wr_idx;
        case ({push, pop})
            2'b11: begin
                // Replace-top, or straight pass-through when nothing is stored.
                dout_valid_d = 1'b1;
                if (is_empty) begin
                    dout_d = din;
                end else begin
                    dout_d    = top_word;
                    mem_we    = 1'b1;
                    mem_waddr = top_idx;
                end
            end
            2'b10: begin
                if (is_full) begin
                    overflow_d = 1'b1;
                end else begin
                    mem_we  = 1'b1;
                    count_d = count_q + ONE_C;
                end
            end
            2'b01: begin
                if (is_empty) begin
                    underflow_d = 1'b1;
                end else begin
                    dout_d       = top_word;
                    dout_valid_d = 1'b1;
                    count_d      = count_q - ONE_C;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr_n && mem_we) begin
            mem_q[mem_waddr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign top         = is_empty ? '0 : top_word;
    assign count       = count_q;
    assign empty       = is_empty;
    assign full        = is_full;
    assign almost_full = (count_q >= AF_C);
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule
